// File: rtl/opl3_host_if_if.sv
// Host-side bundle for opl3_host_if: CPU port strobes and read-back, plus the
// opl3_reg_wr register-write stream produced from them.
interface opl3_host_if_if;
    typedef struct packed {
        logic       valid;
        logic       bank_num;
        logic [7:0] address;
        logic [7:0] data;
    } opl3_reg_wr_t;

    logic         cs_n;
    logic         wr_n;
    logic         rd_n;
    logic [1:0]   a;
    logic [7:0]   din;
    logic [7:0]   dout;
    logic         wait_n;
    opl3_reg_wr_t opl3_reg_wr;

    modport master (
        output cs_n, wr_n, rd_n, a, din,
        input  dout, wait_n, opl3_reg_wr
    );

    modport slave (
        input  cs_n, wr_n, rd_n, a, din,
        output dout, wait_n, opl3_reg_wr
    );
endinterface

// File: rtl/opl3_host_if.sv
// OPL3 host front end: strobe decode, register-write FIFO and spaced dispatcher.
// Optional OPL3_HOST_SYNC_EN adds 2-flop synchronizers on all host inputs.
module opl3_host_if #(
    parameter int FIFO_DEPTH          = 8,
    parameter int WR_SPACING          = 4,
    parameter int REG_FILE_DATA_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    opl3_host_if_if.slave                  host,
    input  logic [REG_FILE_DATA_WIDTH-1:0] status,
    output logic                           overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = (WR_SPACING > 1) ? $clog2(WR_SPACING) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] ONE_CW   = CW'(1);
    localparam logic [AW-1:0] ONE_AW   = AW'(1);
    localparam logic [SW-1:0] ONE_SW   = SW'(1);
    localparam logic [SW-1:0] RELOAD_C = SW'(WR_SPACING - 1);

    logic [12:0] host_raw_s;
    logic [12:0] host_s;
    logic        cs_s, wr_s, rd_s;
    logic [1:0]  a_s;
    logic [7:0]  din_s;

    logic        wr_prev_q, rd_prev_q;
    logic        wr_ev_s, rd_ev_s, push_req_s, push_s, pop_s;

    logic [16:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] space_cnt_q, space_cnt_d;
    logic [7:0]    addr_lat_q, addr_lat_d;
    logic          bank_lat_q, bank_lat_d;
    logic [17:0]   reg_wr_q, reg_wr_d;
    logic [7:0]    dout_q, dout_d;
    logic          overflow_q, overflow_d;
    logic          wait_n_q, wait_n_d;

    assign host_raw_s = {host.cs_n, host.wr_n, host.rd_n, host.a, host.din};

`ifdef OPL3_HOST_SYNC_EN
    logic [12:0] sync1_q, sync2_q;

    // Two-stage synchronizer; strobes idle high while in reset
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 13'h1C00;
            sync2_q <= 13'h1C00;
        end else begin
            sync1_q <= host_raw_s;
            sync2_q <= sync1_q;
        end
    end
    assign host_s = sync2_q;
`else
    assign host_s = host_raw_s;
`endif

    assign cs_s  = host_s[12];
    assign wr_s  = host_s[11];
    assign rd_s  = host_s[10];
    assign a_s   = host_s[9:8];
    assign din_s = host_s[7:0];

    // Previous strobe levels track the bus even through reset so only true edges count
    always_ff @(posedge clk) begin
        wr_prev_q <= wr_s;
        rd_prev_q <= rd_s;
    end

    // Event decode, FIFO bookkeeping and dispatcher next state
    always_comb begin
        wr_ev_s    = wr_prev_q & ~wr_s & ~cs_s;
        rd_ev_s    = rd_prev_q & ~rd_s & ~cs_s;
        pop_s      = (count_q != {CW{1'b0}}) && (space_cnt_q == {SW{1'b0}});
        push_req_s = wr_ev_s & a_s[0];
        push_s     = push_req_s & ((count_q != DEPTH_C) | pop_s);

        if (wr_ev_s && !a_s[0]) begin
            addr_lat_d = din_s;
            bank_lat_d = a_s[1];
        end else begin
            addr_lat_d = addr_lat_q;
            bank_lat_d = bank_lat_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + ONE_CW;
            2'b01:   count_d = count_q - ONE_CW;
            default: count_d = count_q;
        endcase

        wr_ptr_d = push_s ? (wr_ptr_q + ONE_AW) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + ONE_AW) : rd_ptr_q;

        if (pop_s) begin
            space_cnt_d = RELOAD_C;
            reg_wr_d    = {1'b1, mem_q[rd_ptr_q]};
        end else if (space_cnt_q != {SW{1'b0}}) begin
            space_cnt_d = space_cnt_q - ONE_SW;
            reg_wr_d    = {1'b0, reg_wr_q[16:0]};
        end else begin
            space_cnt_d = space_cnt_q;
            reg_wr_d    = {1'b0, reg_wr_q[16:0]};
        end

        if (rd_ev_s) begin
            dout_d = a_s[0] ? 8'hFF : 8'(status);
        end else begin
            dout_d = dout_q;
        end

        overflow_d = overflow_q | (push_req_s & ~push_s);
        wait_n_d   = (count_d != DEPTH_C);
    end

    // Entry storage needs no reset: pointers and count define what is valid
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {bank_lat_q, addr_lat_q, din_s};
        end
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            count_q     <= {CW{1'b0}};
            space_cnt_q <= {SW{1'b0}};
            addr_lat_q  <= 8'h00;
            bank_lat_q  <= 1'b0;
            reg_wr_q    <= 18'h00000;
            dout_q      <= 8'h00;
            overflow_q  <= 1'b0;
            wait_n_q    <= 1'b1;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            space_cnt_q <= space_cnt_d;
            addr_lat_q  <= addr_lat_d;
            bank_lat_q  <= bank_lat_d;
            reg_wr_q    <= reg_wr_d;
            dout_q      <= dout_d;
            overflow_q  <= overflow_d;
            wait_n_q    <= wait_n_d;
        end
    end

    assign host.dout        = dout_q;
    assign host.wait_n      = wait_n_q;
    assign host.opl3_reg_wr = reg_wr_q;
    assign overflow         = overflow_q;
endmodule

// File: tb/tb_opl3_host_if.sv
// Bench for opl3_host_if: two instances (spacing 4 and 64) share one host bus and
// are compared every cycle against a queue-and-timestamp reference model.
module tb_opl3_host_if;
    localparam int DEPTH = 8;
    localparam int SP0   = 4;
    localparam int SP1   = 64;

    logic       clk = 1'b0;
    logic       reset, cs_n, wr_n, rd_n;
    logic [1:0] a;
    logic [7:0] din, status;
    logic       ovf0, ovf1;

    always #5 clk = ~clk;

    opl3_host_if_if bus0 ();
    opl3_host_if_if bus1 ();

    assign bus0.cs_n = cs_n;
    assign bus0.wr_n = wr_n;
    assign bus0.rd_n = rd_n;
    assign bus0.a    = a;
    assign bus0.din  = din;
    assign bus1.cs_n = cs_n;
    assign bus1.wr_n = wr_n;
    assign bus1.rd_n = rd_n;
    assign bus1.a    = a;
    assign bus1.din  = din;

    opl3_host_if #(.FIFO_DEPTH(DEPTH), .WR_SPACING(SP0), .REG_FILE_DATA_WIDTH(8)) dut0 (
        .clk(clk), .reset(reset), .host(bus0), .status(status), .overflow(ovf0));
    opl3_host_if #(.FIFO_DEPTH(DEPTH), .WR_SPACING(SP1), .REG_FILE_DATA_WIDTH(8)) dut1 (
        .clk(clk), .reset(reset), .host(bus1), .status(status), .overflow(ovf1));

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model state: circular queue per instance plus "next allowed pop" cycle
    int          cyc      = 0;
    logic        mprev_wr = 1'b1;
    logic        mprev_rd = 1'b1;
    logic [16:0] mbuf  [2][64];
    int          mhead [2];
    int          msize [2];
    int          mnext [2];
    logic        movf  [2];
    logic        mwait [2];
    logic        mbank [2];
    logic [7:0]  maddr [2];
    logic [7:0]  mdout [2];
    logic [17:0] mout  [2];

    int         log0_t [$];
    logic [7:0] log0_d [$];
    int         n_v1    = 0;
    logic [7:0] last1_d = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        logic wr_ev, rd_ev, pop;
        int   sz, sp;
        wr_ev = mprev_wr & ~wr_n & ~cs_n;
        rd_ev = mprev_rd & ~rd_n & ~cs_n;
        for (int k = 0; k < 2; k++) begin
            sp = (k == 0) ? SP0 : SP1;
            if (reset) begin
                mhead[k] = 0;
                msize[k] = 0;
                mnext[k] = 0;
                movf[k]  = 1'b0;
                mwait[k] = 1'b1;
                mbank[k] = 1'b0;
                maddr[k] = 8'h00;
                mdout[k] = 8'h00;
                mout[k]  = 18'h00000;
            end else begin
                sz  = msize[k];
                pop = (sz > 0) && (cyc >= mnext[k]);
                if (pop) begin
                    mout[k]  = {1'b1, mbuf[k][mhead[k]]};
                    mhead[k] = (mhead[k] + 1) % 64;
                    msize[k] = msize[k] - 1;
                    mnext[k] = cyc + sp;
                end else begin
                    mout[k][17] = 1'b0;
                end
                if (wr_ev && a[0]) begin
                    if (sz < DEPTH || pop) begin
                        mbuf[k][(mhead[k] + msize[k]) % 64] = {mbank[k], maddr[k], din};
                        msize[k] = msize[k] + 1;
                    end else begin
                        movf[k] = 1'b1;
                    end
                end else if (wr_ev) begin
                    maddr[k] = din;
                    mbank[k] = a[1];
                end
                if (rd_ev) mdout[k] = a[0] ? 8'hFF : status;
                mwait[k] = (msize[k] != DEPTH);
            end
        end
        mprev_wr = wr_n;
        mprev_rd = rd_n;
    endtask

    task automatic compare_all();
        check("reg_wr0", 32'(bus0.opl3_reg_wr), 32'(mout[0]));
        check("wait_n0", 32'(bus0.wait_n),      32'(mwait[0]));
        check("ovf0",    32'(ovf0),             32'(movf[0]));
        check("dout0",   32'(bus0.dout),        32'(mdout[0]));
        check("reg_wr1", 32'(bus1.opl3_reg_wr), 32'(mout[1]));
        check("wait_n1", 32'(bus1.wait_n),      32'(mwait[1]));
        check("ovf1",    32'(ovf1),             32'(movf[1]));
        check("dout1",   32'(bus1.dout),        32'(mdout[1]));
    endtask

    // One clock: model advances on the rising edge, outputs are sampled on the falling edge
    task automatic step();
        @(posedge clk);
        model_update();
        cyc++;
        @(negedge clk);
        if (chk_en) compare_all();
        if (bus0.opl3_reg_wr.valid) begin
            log0_t.push_back(cyc);
            log0_d.push_back(bus0.opl3_reg_wr.data);
        end
        if (bus1.opl3_reg_wr.valid) begin
            n_v1++;
            last1_d = bus1.opl3_reg_wr.data;
        end
    endtask

    task automatic host_write(input logic [1:0] av, input logic [7:0] dv);
        cs_n = 1'b0; a = av; din = dv; wr_n = 1'b0;
        step();
        wr_n = 1'b1; cs_n = 1'b1;
        step();
    endtask

    task automatic host_read(input logic [1:0] av);
        cs_n = 1'b0; a = av; rd_n = 1'b0;
        step();
        rd_n = 1'b1; cs_n = 1'b1;
        step();
    endtask

    initial begin
        reset = 1'b1; cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
        a = 2'b00; din = 8'h00; status = 8'h00;
        repeat (3) step();
        chk_en = 1'b1;
        check("rst_dout",   32'(bus0.dout),        32'h0);
        check("rst_wait_n", 32'(bus0.wait_n),      32'h1);
        check("rst_ovf",    32'(ovf0),             32'h0);
        check("rst_reg_wr", 32'(bus1.opl3_reg_wr), 32'h0);
        reset = 1'b0;
        step();

        // Address then data write: one pulse two cycles after the data strobe
        host_write(2'b10, 8'h04);
        host_write(2'b01, 8'h80);
        check("first_wr0", 32'(bus0.opl3_reg_wr), 32'h30480);
        check("first_wr1", 32'(bus1.opl3_reg_wr), 32'h30480);
        step();
        check("first_wr_once", 32'(bus0.opl3_reg_wr.valid), 32'h0);

        // Status read-back
        status = 8'hC0;
        host_read(2'b00);
        check("rd_status", 32'(bus0.dout), 32'hC0);
        host_read(2'b01);
        check("rd_data_port", 32'(bus0.dout), 32'hFF);

        // Five back-to-back data writes
        log0_t.delete();
        log0_d.delete();
        for (int i = 0; i < 5; i++) host_write(2'b01, 8'h10 + 8'(i));
        repeat (30) step();
        check("burst_count", 32'(log0_t.size()), 32'd5);
        for (int i = 0; i < log0_t.size(); i++) begin
            check("burst_data", 32'(log0_d[i]), 32'h10 + 32'(i));
            if (i > 0) check("burst_gap", 32'(log0_t[i] - log0_t[i-1]), 32'(SP0));
        end

        // Reset with entries still queued in the slow instance
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst2_wait_n", 32'(bus1.wait_n),      32'h1);
        check("rst2_ovf",    32'(ovf1),             32'h0);
        check("rst2_dout",   32'(bus1.dout),        32'h0);
        check("rst2_reg_wr", 32'(bus1.opl3_reg_wr), 32'h0);
        n_v1 = 0;
        repeat (80) step();
        check("rst2_no_dispatch", 32'(n_v1), 32'd0);
        host_write(2'b01, 8'h55);
        check("post_rst_wr", 32'(bus1.opl3_reg_wr), 32'h20055);

        // Nine writes while the slow dispatcher is stalled
        for (int i = 0; i < 9; i++) begin
            host_write(2'b01, 8'hA0 + 8'(i));
            if (i == 6) check("fill7_wait_n", 32'(bus1.wait_n), 32'h1);
            if (i == 7) check("full_wait_n",  32'(bus1.wait_n), 32'h0);
        end
        check("ovf_set",  32'(ovf1), 32'h1);
        check("ovf_fast", 32'(ovf0), 32'h0);
        n_v1 = 0;
        repeat (530) step();
        check("stall_dispatch_count", 32'(n_v1),    32'd8);
        check("stall_last_data",      32'(last1_d), 32'hA7);
        check("ovf_sticky",           32'(ovf1),    32'h1);

        // Held strobe gives one push; deselected strobe gives none
        log0_t.delete();
        log0_d.delete();
        cs_n = 1'b0; a = 2'b01; din = 8'h3C; wr_n = 1'b0;
        repeat (20) step();
        wr_n = 1'b1; cs_n = 1'b1;
        repeat (10) step();
        check("held_count", 32'(log0_t.size()), 32'd1);
        if (log0_d.size() > 0) check("held_data", 32'(log0_d[0]), 32'h3C);
        cs_n = 1'b1; din = 8'hC3; wr_n = 1'b0;
        step();
        wr_n = 1'b1;
        repeat (10) step();
        check("no_cs_count", 32'(log0_t.size()), 32'd1);

        // Randomized traffic, including simultaneous read/write and occasional reset
        for (int i = 0; i < 400; i++) begin
            cs_n   = ($urandom_range(3) == 0);
            wr_n   = 1'($urandom_range(1));
            rd_n   = 1'($urandom_range(1));
            a      = 2'($urandom);
            din    = 8'($urandom);
            status = 8'($urandom);
            reset  = ($urandom_range(127) == 0);
            step();
        end
        reset = 1'b0; cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
        repeat (5) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
